// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single synchronous memory port.
// Round-robin on conflict; reads return one cycle after grant, stores complete in the grant cycle.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    OP_DMEM_BYTE = 2'd0,
    OP_DMEM_HALF = 2'd1,
    OP_DMEM_TRPL = 2'd2,
    OP_DMEM_WORD = 2'd3
  } op_dmem_size;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          res,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wen,
  input  op_dmem_size   d_size,
  input  logic          d_zero_ex,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_wen,
  output logic          mem_ren,
  output op_dmem_size   mem_size,
  output logic          mem_zero_ex,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   win_d, win_i, accept;

  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // data wins when alone, or on conflict when fetch was granted last
  always_comb begin
    win_d  = d_req & (~i_req | ~last_d_q);
    win_i  = i_req & ~win_d;
    accept = (state_q == IDLE) & (i_req | d_req) & ~res;
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          last_d_d = win_d;
          if (win_i)       state_d = RESP_I;
          else if (~d_wen) state_d = RESP_D;
        end
      end
      RESP_I:  state_d = IDLE;
      RESP_D:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    i_rvalid    = 1'b0;
    d_rvalid    = 1'b0;
    i_rdata     = '0;
    d_rdata     = '0;
    mem_req     = 1'b0;
    mem_wen     = 1'b0;
    mem_ren     = 1'b0;
    mem_size    = OP_DMEM_WORD;
    mem_zero_ex = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          i_gnt   = win_i;
          d_gnt   = win_d;
          mem_req = 1'b1;
          mem_wen = d_wen & win_d;
          mem_ren = ~(d_wen & win_d);
          if (win_d) begin
            mem_addr    = d_addr;
            mem_size    = d_size;
            mem_zero_ex = d_zero_ex;
            mem_wdata   = d_wdata;
          end else begin
            mem_addr = i_addr;
          end
        end
      end
      RESP_I: begin
        if (~res) begin
          i_rvalid = 1'b1;
          i_rdata  = mem_rdata;
        end
      end
      RESP_D: begin
        if (~res) begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed memory model
// that applies size and sign/zero extension on reads.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          res;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_wen, d_zero_ex;
  op_dmem_size   d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_wen, mem_ren, mem_zero_ex;
  op_dmem_size   mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .res(res),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_size(d_size),
    .d_zero_ex(d_zero_ex), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_size(mem_size), .mem_zero_ex(mem_zero_ex),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // memory model: cells reset to 0xFF, bytes 4..7 preloaded with 0xDEADBEEF
  logic [7:0] mem [16];
  always @(posedge clk) begin
    logic [31:0] r;
    int n;
    if (res) begin
      for (int k = 0; k < 16; k++) mem[k] = 8'hFF;
      mem[4] = 8'hEF; mem[5] = 8'hBE; mem[6] = 8'hAD; mem[7] = 8'hDE;
      mem_rdata <= '0;
    end else if (mem_req) begin
      n = int'(mem_size) + 1;
      if (mem_wen) begin
        for (int j = 0; j < n; j++)
          mem[(int'(mem_addr) + j) % 16] = mem_wdata[j*8 +: 8];
      end else if (mem_ren) begin
        r = '0;
        for (int j = 0; j < n; j++)
          r[j*8 +: 8] = mem[(int'(mem_addr) + j) % 16];
        if (!mem_zero_ex && n < 4 && r[n*8-1])
          for (int j = n*8; j < 32; j++) r[j] = 1'b1;
        mem_rdata <= r;
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to the low phase; inputs change here, checks follow after #1
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    res = 1'b1;
    i_req = 1'b1; i_addr = '0;
    d_req = 1'b1; d_wen = 1'b0; d_size = OP_DMEM_WORD;
    d_zero_ex = 1'b0; d_addr = '0; d_wdata = '0;
    cyc(); cyc(); #1;
    chk1("rst_i_gnt", i_gnt, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_i_rvalid", i_rvalid, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);

    // single fetch
    cyc(); res = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 4'd4; #1;
    chk1("f_i_gnt", i_gnt, 1'b1);
    chk1("f_d_gnt", d_gnt, 1'b0);
    chk1("f_mem_req", mem_req, 1'b1);
    chk1("f_mem_ren", mem_ren, 1'b1);
    chk32("f_mem_addr", 32'(mem_addr), 32'd4);
    chk32("f_mem_size", 32'(mem_size), 32'(OP_DMEM_WORD));
    cyc(); i_req = 1'b0; #1;
    chk1("f_rvalid", i_rvalid, 1'b1);
    chk32("f_rdata", i_rdata, 32'hDEADBEEF);
    chk1("f_resp_mem_req", mem_req, 1'b0);
    cyc(); #1;
    chk1("f_idle_rvalid", i_rvalid, 1'b0);
    chk32("f_idle_rdata", i_rdata, 32'h0);

    // fetch and load both from reset
    cyc(); res = 1'b1; #1;
    cyc(); res = 1'b0;
    i_req = 1'b1; i_addr = 4'd4;
    d_req = 1'b1; d_wen = 1'b0; d_size = OP_DMEM_WORD; d_addr = 4'd4; #1;
    chk1("c0_i_gnt", i_gnt, 1'b1);
    chk1("c0_d_gnt", d_gnt, 1'b0);
    cyc(); i_req = 1'b0; #1;
    chk1("c1_i_rvalid", i_rvalid, 1'b1);
    chk32("c1_i_rdata", i_rdata, 32'hDEADBEEF);
    chk1("c1_d_gnt", d_gnt, 1'b0);
    cyc(); #1;
    chk1("c2_d_gnt", d_gnt, 1'b1);
    chk1("c2_mem_wen", mem_wen, 1'b0);
    cyc(); d_req = 1'b0; #1;
    chk1("c3_d_rvalid", d_rvalid, 1'b1);
    chk32("c3_d_rdata", d_rdata, 32'hDEADBEEF);

    // three back-to-back stores, then a word load
    cyc(); d_req = 1'b1; d_wen = 1'b1;
    d_size = OP_DMEM_BYTE; d_addr = 4'd0; d_wdata = 32'h000000A5; #1;
    chk1("st0_gnt", d_gnt, 1'b1);
    chk1("st0_wen", mem_wen, 1'b1);
    chk1("st0_ren", mem_ren, 1'b0);
    chk32("st0_wdata", mem_wdata, 32'h000000A5);
    cyc(); d_size = OP_DMEM_HALF; d_addr = 4'd2; d_wdata = 32'h00001234; #1;
    chk1("st1_gnt", d_gnt, 1'b1);
    cyc(); d_size = OP_DMEM_WORD; d_addr = 4'd4; d_wdata = 32'hCAFEF00D; #1;
    chk1("st2_gnt", d_gnt, 1'b1);
    cyc(); d_wen = 1'b0; d_addr = 4'd0; d_wdata = '0; #1;
    chk1("ld_gnt", d_gnt, 1'b1);
    cyc(); d_req = 1'b0; #1;
    chk1("ld_rvalid", d_rvalid, 1'b1);
    chk32("ld_rdata", d_rdata, 32'h1234FFA5);

    // signed vs zero-extended byte load of 0x80
    cyc(); d_req = 1'b1; d_wen = 1'b1; d_size = OP_DMEM_BYTE;
    d_addr = 4'd8; d_wdata = 32'h00000080; #1;
    chk1("sb_gnt", d_gnt, 1'b1);
    cyc(); d_wen = 1'b0; d_zero_ex = 1'b0; d_wdata = '0; #1;
    chk1("lbs_gnt", d_gnt, 1'b1);
    chk1("lbs_zx", mem_zero_ex, 1'b0);
    cyc(); d_zero_ex = 1'b1; #1;
    chk1("lbs_rvalid", d_rvalid, 1'b1);
    chk32("lbs_rdata", d_rdata, 32'hFFFFFF80);
    chk1("lbs_resp_gnt", d_gnt, 1'b0);
    cyc(); #1;
    chk1("lbu_gnt", d_gnt, 1'b1);
    chk1("lbu_zx", mem_zero_ex, 1'b1);
    cyc(); d_req = 1'b0; d_zero_ex = 1'b0; #1;
    chk1("lbu_rvalid", d_rvalid, 1'b1);
    chk32("lbu_rdata", d_rdata, 32'h00000080);

    // continuous dual requests: last grant was data, so fetch leads
    cyc(); i_req = 1'b1; i_addr = 4'd0;
    d_req = 1'b1; d_wen = 1'b0; d_size = OP_DMEM_WORD; d_addr = 4'd4;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc();
      #1;
      chk1("rr_i_gnt", i_gnt, (k % 4) == 0);
      chk1("rr_d_gnt", d_gnt, (k % 4) == 2);
      chk1("rr_i_rvalid", i_rvalid, (k % 4) == 1);
      chk1("rr_d_rvalid", d_rvalid, (k % 4) == 3);
      chk32("rr_i_rdata", i_rdata, ((k % 4) == 1) ? 32'h1234FFA5 : 32'h0);
      chk32("rr_d_rdata", d_rdata, ((k % 4) == 3) ? 32'hCAFEF00D : 32'h0);
    end

    // reset in the RESP_I cycle drops the response
    cyc(); d_req = 1'b0; i_req = 1'b1; i_addr = 4'd4; #1;
    chk1("rr_end_i_gnt", i_gnt, 1'b1);
    cyc(); i_req = 1'b0; res = 1'b1; #1;
    chk1("rsti_rvalid", i_rvalid, 1'b0);
    chk32("rsti_rdata", i_rdata, 32'h0);
    cyc(); res = 1'b0; #1;
    chk1("rsti_after_rvalid", i_rvalid, 1'b0);
    chk1("rsti_after_mem_req", mem_req, 1'b0);
    cyc(); i_req = 1'b1; i_addr = 4'd4; #1;
    chk1("rsti_new_gnt", i_gnt, 1'b1);
    cyc(); i_req = 1'b0; #1;
    chk1("rsti_new_rvalid", i_rvalid, 1'b1);
    chk32("rsti_new_rdata", i_rdata, 32'hDEADBEEF);
    cyc(); #1;
    chk1("final_rvalid", i_rvalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
